// File: rtl/ch0re_retire_trace.sv
// rtl/ch0re_retire_trace.sv - retirement trace capture buffer with PC-match trigger and drain port
// Records retired instructions into a circular buffer; freezes after trigger plus POST_TRIG captures.
module ch0re_retire_trace #(
  parameter int XLEN      = 64,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_ret_valid,
  input  logic [XLEN-1:0]            i_ret_pc,
  input  logic [4:0]                 i_ret_rd,
  input  logic                       i_ret_wen,
  input  logic [XLEN-1:0]            i_ret_wdata,
  input  logic                       i_arm,
  input  logic                       i_clear,
  input  logic                       i_trig_en,
  input  logic [XLEN-1:0]            i_trig_pc,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [XLEN-1:0]            o_rd_pc,
  output logic [4:0]                 o_rd_rd,
  output logic                       o_rd_wen,
  output logic [XLEN-1:0]            o_rd_wdata,
  output logic [1:0]                 o_state,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
  output logic                       o_trig_hit,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int EW = 2*XLEN + 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            trig_q, trig_d;
  logic            ovf_q, ovf_d;
  logic            cap;
  logic            hit;
  logic            rd_valid;
  logic            xfer;
  logic [AW-1:0]   rd_idx;
  logic [EW-1:0]   rd_entry;
  logic [EW-1:0]   mem_q [DEPTH];

  assign hit      = i_ret_valid & i_trig_en & (i_ret_pc == i_trig_pc);
  assign rd_valid = (state_q == ST_FROZEN) && (occ_q != '0);
  assign xfer     = rd_valid & i_rd_ready;
  // Oldest entry; at full occupancy the low bits are zero so this lands on wptr itself.
  assign rd_idx   = wptr_q - occ_q[AW-1:0];
  assign rd_entry = mem_q[rd_idx];

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    trig_d  = trig_q;
    ovf_d   = ovf_q;
    cap     = 1'b0;
    if (i_clear) begin
      state_d = ST_IDLE;
      wptr_d  = '0;
      occ_d   = '0;
      cnt_d   = '0;
      trig_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (i_arm && (state_q == ST_IDLE || state_q == ST_FROZEN)) begin
      state_d = ST_ARMED;
      wptr_d  = '0;
      occ_d   = '0;
      cnt_d   = '0;
      trig_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (i_ret_valid) begin
            cap = 1'b1;
            if (hit) begin
              trig_d = 1'b1;
              if (POST_TRIG == 0) begin
                state_d = ST_FROZEN;
              end else begin
                cnt_d   = AW'(POST_TRIG);
                state_d = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (i_ret_valid) begin
            cap   = 1'b1;
            cnt_d = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
              state_d = ST_FROZEN;
            end
          end
        end
        ST_FROZEN: begin
          if (xfer) begin
            occ_d = occ_q - OW'(1);
          end
        end
        default: ;
      endcase
      if (cap) begin
        wptr_d = wptr_q + AW'(1);
        if (occ_q == OW'(DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          occ_d = occ_q + OW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap && !rst) begin
      mem_q[wptr_q] <= {i_ret_pc, i_ret_rd, i_ret_wen, i_ret_wdata};
    end
  end

  assign o_rd_valid  = rd_valid;
  assign o_rd_pc     = rd_valid ? rd_entry[EW-1 -: XLEN] : '0;
  assign o_rd_rd     = rd_valid ? rd_entry[XLEN+5:XLEN+1] : '0;
  assign o_rd_wen    = rd_valid ? rd_entry[XLEN] : 1'b0;
  assign o_rd_wdata  = rd_valid ? rd_entry[XLEN-1:0] : '0;
  assign o_state     = state_q;
  assign o_occupancy = occ_q;
  assign o_trig_hit  = trig_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_ch0re_retire_trace.sv
// tb/tb_ch0re_retire_trace.sv - directed bench for ch0re_retire_trace
// Instance a uses DEPTH=4/POST_TRIG=2, instance b uses DEPTH=4/POST_TRIG=0; both share stimulus.
module tb_ch0re_retire_trace;

  logic        clk = 1'b0;
  logic        rst;
  logic        ret_valid;
  logic [63:0] ret_pc;
  logic [4:0]  ret_rd;
  logic        ret_wen;
  logic [63:0] ret_wdata;
  logic        arm;
  logic        clear;
  logic        trig_en;
  logic [63:0] trig_pc;
  logic        rd_ready;

  logic        a_valid, b_valid;
  logic [63:0] a_pc, b_pc, a_wdata, b_wdata;
  logic [4:0]  a_rd, b_rd;
  logic        a_wen, b_wen;
  logic [1:0]  a_state, b_state;
  logic [2:0]  a_occ, b_occ;
  logic        a_trig, b_trig, a_ovf, b_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ch0re_retire_trace #(.XLEN(64), .DEPTH(4), .POST_TRIG(2)) dut_a (
    .clk(clk), .rst(rst), .i_ret_valid(ret_valid), .i_ret_pc(ret_pc), .i_ret_rd(ret_rd),
    .i_ret_wen(ret_wen), .i_ret_wdata(ret_wdata), .i_arm(arm), .i_clear(clear),
    .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_rd_ready(rd_ready),
    .o_rd_valid(a_valid), .o_rd_pc(a_pc), .o_rd_rd(a_rd), .o_rd_wen(a_wen),
    .o_rd_wdata(a_wdata), .o_state(a_state), .o_occupancy(a_occ),
    .o_trig_hit(a_trig), .o_overflow(a_ovf)
  );

  ch0re_retire_trace #(.XLEN(64), .DEPTH(4), .POST_TRIG(0)) dut_b (
    .clk(clk), .rst(rst), .i_ret_valid(ret_valid), .i_ret_pc(ret_pc), .i_ret_rd(ret_rd),
    .i_ret_wen(ret_wen), .i_ret_wdata(ret_wdata), .i_arm(arm), .i_clear(clear),
    .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_rd_ready(rd_ready),
    .o_rd_valid(b_valid), .o_rd_pc(b_pc), .o_rd_rd(b_rd), .o_rd_wen(b_wen),
    .o_rd_wdata(b_wdata), .o_state(b_state), .o_occupancy(b_occ),
    .o_trig_hit(b_trig), .o_overflow(b_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                        input logic [63:0] wdata);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_rd    = rd;
    ret_wen   = wen;
    ret_wdata = wdata;
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic start_capture();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    arm   = 1'b1;
    tick();
    arm   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", a_state); end
    n_tests++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", a_occ); end
    n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", a_valid); end
    n_tests++; if (a_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", a_pc); end
    n_tests++; if ({a_trig, a_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {a_trig, a_ovf}); end
  endtask

  task automatic test_capture();
    trig_en = 1'b0;
    start_capture();
    retire(64'h100, 5'd1, 1'b1, 64'h1);
    retire(64'h104, 5'd2, 1'b1, 64'h2);
    retire(64'h108, 5'd3, 1'b1, 64'h3);
    n_tests++; if (a_occ !== 3'd3) begin n_fail++; $display("FAIL capture_occ got %0d exp 3", a_occ); end
    n_tests++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL capture_state got %0d exp 1", a_state); end
    n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL capture_valid got %b exp 0", a_valid); end
    n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL capture_ovf got %b exp 0", a_ovf); end
  endtask

  task automatic test_trigger();
    logic [63:0] exp_pc [4];
    exp_pc[0] = 64'h108; exp_pc[1] = 64'h10c; exp_pc[2] = 64'h110; exp_pc[3] = 64'h114;
    trig_en = 1'b1;
    trig_pc = 64'h10c;
    start_capture();
    for (int i = 0; i < 8; i++) begin
      retire(64'h100 + 64'(4*i), 5'(i), 1'b1, 64'h1000 + 64'(i));
      if (i == 3) begin
        n_tests++; if (a_trig !== 1'b1) begin n_fail++; $display("FAIL trig_hit got %b exp 1", a_trig); end
        n_tests++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL trig_post got %0d exp 2", a_state); end
      end
      if (i == 4) begin
        n_tests++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL trig_post2 got %0d exp 2", a_state); end
      end
      if (i == 5) begin
        n_tests++; if (a_state !== 2'd3) begin n_fail++; $display("FAIL trig_frozen got %0d exp 3", a_state); end
      end
    end
    n_tests++; if (a_occ !== 3'd4) begin n_fail++; $display("FAIL trig_occ got %0d exp 4", a_occ); end
    n_tests++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL trig_ovf got %b exp 1", a_ovf); end
    n_tests++; if (a_rd !== 5'd2 || a_wdata !== 64'h1002) begin
      n_fail++; $display("FAIL trig_entry got rd %0d wdata %h exp rd 2 wdata 1002", a_rd, a_wdata);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (a_valid !== 1'b1 || a_pc !== exp_pc[i]) begin
        n_fail++; $display("FAIL drain%0d got valid %b pc %h exp valid 1 pc %h", i, a_valid, a_pc, exp_pc[i]);
      end
      tick();
    end
    rd_ready = 1'b0;
    n_tests++; if (a_occ !== 3'd0 || a_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_end got occ %0d valid %b exp 0 0", a_occ, a_valid);
    end
    n_tests++; if (a_state !== 2'd3) begin n_fail++; $display("FAIL drain_state got %0d exp 3", a_state); end
  endtask

  task automatic test_post0();
    trig_en = 1'b1;
    trig_pc = 64'h100;
    start_capture();
    retire(64'h100, 5'd5, 1'b1, 64'h2a);
    n_tests++; if (b_state !== 2'd3) begin n_fail++; $display("FAIL post0_state got %0d exp 3", b_state); end
    n_tests++; if (b_occ !== 3'd1) begin n_fail++; $display("FAIL post0_occ got %0d exp 1", b_occ); end
    n_tests++; if ({b_pc, b_rd, b_wen, b_wdata} !== {64'h100, 5'd5, 1'b1, 64'h2a}) begin
      n_fail++; $display("FAIL post0_entry got %h %0d %b %h exp 100 5 1 2a", b_pc, b_rd, b_wen, b_wdata);
    end
    retire(64'h104, 5'd6, 1'b1, 64'h2b);
    n_tests++; if (b_occ !== 3'd1 || b_pc !== 64'h100) begin
      n_fail++; $display("FAIL post0_drop got occ %0d pc %h exp 1 100", b_occ, b_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic        rdy [5];
    logic [63:0] exp_pc [5];
    int          xfers;
    rdy[0] = 1'b0; rdy[1] = 1'b1; rdy[2] = 1'b0; rdy[3] = 1'b1; rdy[4] = 1'b1;
    exp_pc[0] = 64'h200; exp_pc[1] = 64'h204; exp_pc[2] = 64'h204; exp_pc[3] = 64'h208; exp_pc[4] = 64'h0;
    xfers = 0;
    trig_en = 1'b1;
    trig_pc = 64'h200;
    start_capture();
    retire(64'h200, 5'd1, 1'b0, 64'h0);
    retire(64'h204, 5'd2, 1'b0, 64'h0);
    retire(64'h208, 5'd3, 1'b0, 64'h0);
    n_tests++; if (a_state !== 2'd3 || a_occ !== 3'd3) begin
      n_fail++; $display("FAIL bp_setup got state %0d occ %0d exp 3 3", a_state, a_occ);
    end
    for (int i = 0; i < 5; i++) begin
      rd_ready = rdy[i];
      if (a_valid && rd_ready) xfers++;
      tick();
      n_tests++; if (a_pc !== exp_pc[i]) begin
        n_fail++; $display("FAIL bp_pc%0d got %h exp %h", i, a_pc, exp_pc[i]);
      end
    end
    rd_ready = 1'b0;
    n_tests++; if (xfers != 3) begin n_fail++; $display("FAIL bp_xfers got %0d exp 3", xfers); end
    n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid got %b exp 0", a_valid); end
  endtask

  task automatic test_priority();
    trig_en = 1'b1;
    trig_pc = 64'h10c;
    start_capture();
    for (int i = 0; i < 6; i++) retire(64'h100 + 64'(4*i), 5'(i), 1'b1, 64'(i));
    n_tests++; if (a_state !== 2'd3 || a_occ !== 3'd4) begin
      n_fail++; $display("FAIL prio_setup got state %0d occ %0d exp 3 4", a_state, a_occ);
    end
    arm = 1'b1; clear = 1'b1; rd_ready = 1'b1;
    tick();
    arm = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    n_tests++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL prio_state got %0d exp 0", a_state); end
    n_tests++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL prio_occ got %0d exp 0", a_occ); end
    n_tests++; if ({a_trig, a_ovf, a_valid} !== 3'b000) begin
      n_fail++; $display("FAIL prio_flags got %b exp 000", {a_trig, a_ovf, a_valid});
    end
  endtask

  task automatic test_reset_mid_post();
    trig_en = 1'b1;
    trig_pc = 64'h300;
    start_capture();
    retire(64'h300, 5'd1, 1'b1, 64'h1);
    retire(64'h304, 5'd2, 1'b1, 64'h2);
    n_tests++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL rpost_setup got %0d exp 2", a_state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if ({a_state, a_occ, a_trig, a_ovf, a_valid} !== 8'h0) begin
      n_fail++; $display("FAIL rpost_state got st %0d occ %0d flags %b exp all 0", a_state, a_occ, {a_trig, a_ovf, a_valid});
    end
    n_tests++; if (a_pc !== 64'h0 || a_wdata !== 64'h0) begin
      n_fail++; $display("FAIL rpost_data got pc %h wdata %h exp 0 0", a_pc, a_wdata);
    end
    retire(64'h308, 5'd3, 1'b1, 64'h3);
    retire(64'h300, 5'd4, 1'b1, 64'h4);
    n_tests++; if (a_state !== 2'd0 || a_occ !== 3'd0) begin
      n_fail++; $display("FAIL rpost_ignore got st %0d occ %0d exp 0 0", a_state, a_occ);
    end
  endtask

  initial begin
    rst = 1'b1; ret_valid = 1'b0; ret_pc = '0; ret_rd = '0; ret_wen = 1'b0; ret_wdata = '0;
    arm = 1'b0; clear = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    test_reset();
    test_capture();
    test_trigger();
    test_post0();
    test_back_to_back();
    test_priority();
    test_reset_mid_post();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ch0re_retire_trace.md
Name: ch0re_retire_trace

Overview:
Synthesizable retirement-trace capture unit for the ch0re pipeline, tapped at the write-back stage. It records every retired instruction (PC, rd, write-enable, write-back data) into a parametrised circular buffer. An optional PC-match trigger freezes the buffer a programmable number of retirements after the trigger instruction. The frozen history is then drained oldest-first through a valid/ready port, replacing cycle-by-cycle printf tracing with an on-chip, post-mortem pipeline trace.

Parameters:
XLEN, 64, width of PC and write-back data fields.
DEPTH, 16, number of trace entries; must be a power of 2 and at least 2.
POST_TRIG, 4, retirements captured after the trigger entry; legal range 0..DEPTH-1.

Ports:
clk  in  1  clock.
rst  in  1  reset. Synchronous, active-high.
i_ret_valid  in  1  an instruction retires this cycle.
i_ret_pc  in  XLEN  PC of the retiring instruction.
i_ret_rd  in  5  destination register.
i_ret_wen  in  1  register-file write enable.
i_ret_wdata  in  XLEN  write-back data.
i_arm  in  1  pulse: clear the buffer and start capturing.
i_clear  in  1  pulse: clear the buffer and go idle.
i_trig_en  in  1  enables the PC-match trigger.
i_trig_pc  in  XLEN  trigger PC.
i_rd_ready  in  1  consumer accepts the current readout entry.
o_rd_valid  out  1  a readout entry is presented.
o_rd_pc  out  XLEN  readout PC.
o_rd_rd  out  5  readout rd.
o_rd_wen  out  1  readout wen.
o_rd_wdata  out  XLEN  readout write-back data.
o_state  out  2  current state: IDLE=0, ARMED=1, POST=2, FROZEN=3.
o_occupancy  out  $clog2(DEPTH+1)  number of valid entries.
o_trig_hit  out  1  sticky; the trigger has fired since the last arm or clear.
o_overflow  out  1  sticky; an unread entry has been overwritten since the last arm or clear.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state becomes IDLE; wptr, occupancy and the post-trigger counter become 0.
  - all outputs read 0; buffer contents are don't-care.
- Capture:
  - A capture writes {pc, rd, wen, wdata} at wptr.
  - wptr increments modulo DEPTH.
  - occupancy increments, saturating at DEPTH.
  - A capture at occupancy==DEPTH overwrites the oldest entry and sets o_overflow.
- Trigger hit: i_ret_valid & i_trig_en & (i_ret_pc == i_trig_pc).
- State transitions, evaluated in priority order at each clk edge:
  - i_clear (any state): go to IDLE, wptr=0, occupancy=0, o_trig_hit=0, o_overflow=0.
  - else i_arm while in IDLE or FROZEN: go to ARMED with the same zeroing. i_arm is ignored in ARMED and POST.
  - IDLE: no capture.
  - ARMED: capture every i_ret_valid. On a trigger hit the trigger entry is captured and o_trig_hit is set. If POST_TRIG==0, go to FROZEN; otherwise load the counter with POST_TRIG and go to POST.
  - POST: capture every i_ret_valid and decrement the counter on each capture. The capture that brings the counter to 0 moves the state to FROZEN. Further trigger matches are ignored.
  - FROZEN: no capture; retirements are dropped.
- Readout:
  - o_rd_valid = (state==FROZEN) & (occupancy != 0).
  - o_rd_* show the entry at (wptr - occupancy) mod DEPTH, i.e. the oldest entry, combinationally from the array (zero latency).
  - A transfer occurs when o_rd_valid & i_rd_ready; occupancy decrements and the next-oldest entry appears in the next cycle.
  - At occupancy 0 the block stays FROZEN with o_rd_valid=0 until i_arm or i_clear.
- A transfer in the same cycle as i_arm or i_clear is discarded; the clear/arm wins.
- In ARMED/POST, i_ret_valid is the only write source. No readout happens outside FROZEN.
- Asserting rst during POST or readout aborts to IDLE with no further outputs.
- Widths: the counter is $clog2(DEPTH) bits. Pointer arithmetic wraps naturally because DEPTH is a power of 2.

Test Plan:
- DEPTH=4, POST_TRIG=2, trigger off:
  - Stimulus: arm, then retire PCs h100,h104,h108.
  - Required: o_occupancy=3, o_state=ARMED, o_rd_valid=0, o_overflow=0.
- DEPTH=4, POST_TRIG=2, i_trig_pc=h10c:
  - Stimulus: retire h100..h11c, one per cycle.
  - Required: o_trig_hit set when h10c retires; FROZEN after h114. Drain with i_rd_ready=1 yields h108,h10c,h110,h114 in order; o_overflow=1; occupancy reaches 0.
- POST_TRIG=0 with the trigger on the first retirement h100 (rd=5, wen=1, wdata=h2a):
  - Required: FROZEN next cycle, occupancy=1, o_rd = {h100, 5, 1, h2a}. Later retirements are not captured.
- Readout backpressure:
  - Stimulus: FROZEN with 3 entries; i_rd_ready toggles 0,1,0,1,1.
  - Required: o_rd_pc changes only after cycles where i_rd_ready=1; exactly 3 transfers; o_rd_valid drops after the third.
- Priority:
  - Stimulus: i_arm and i_clear asserted together in FROZEN with an active readout transfer.
  - Required: IDLE, occupancy=0, sticky flags 0, no transfer counted.
- Reset mid-POST:
  - Stimulus: assert rst for one cycle.
  - Required: o_state=IDLE and all outputs 0 after that edge; retirements are ignored until i_arm.
